// File: rtl/niosfirmware_mem_loader_pkg.sv
// Shared types and constants for the Nios firmware RAM loader.
//   loader_state_e : loader FSM states
//   lane_idx_t     : byte-lane index inside a 32-bit word (byte 0 = bits [7:0])
package niosfirmware_loader_pkg;

    localparam int LOADER_ADDR_W = 11;
    localparam int LOADER_DEPTH  = 2048;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE
    } loader_state_e;

    typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/niosfirmware_mem_loader.sv
// Nios firmware RAM loader: packs a little-endian byte stream into 32-bit
// words and writes them into the on-chip RAM, holding the CPU in reset while
// busy and reporting an additive checksum of the loaded image.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start, abort                load request (IDLE only) / cancel (while busy)
//   base_addr, word_count       load window, latched on an accepted start
//   in_valid, in_data, in_ready byte-stream handshake
//   mem_*                       RAM write port (single-cycle, no waitrequest)
//   cpu_reset_req, busy         CPU hold / loader activity
//   done, aborted               one-cycle completion pulses
//   checksum                    sum of words written in the current load
module niosfirmware_mem_loader
    import niosfirmware_loader_pkg::*;
#(
    parameter int ADDR_W = LOADER_ADDR_W,
    parameter int DEPTH  = LOADER_DEPTH   // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              cpu_reset_req,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [31:0]       checksum
);

    loader_state_e     state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [ADDR_W:0]   rem, rem_n;
    lane_idx_t         idx, idx_n;
    logic [31:0]       word, word_n;

    logic              in_ready_n, wr_n, busy_n, done_n, aborted_n;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0]       wdata_n, csum_n;
    logic              accept;

    // in_ready is registered and only high in COLLECT, so it doubles as the
    // "state == COLLECT" qualifier for byte acceptance.
    assign accept = in_valid && in_ready;

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        rem_n     = rem;
        idx_n     = idx;
        word_n    = word;
        addr_n    = mem_address;
        wdata_n   = mem_writedata;
        csum_n    = checksum;
        wr_n      = 1'b0;
        done_n    = 1'b0;
        aborted_n = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    csum_n = '0;
                    if (word_count != '0) begin
                        ptr_n   = base_addr;
                        rem_n   = word_count;
                        idx_n   = '0;
                        word_n  = '0;
                        state_n = COLLECT;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (abort) begin
                    // Partial word is simply dropped; nothing reaches the RAM.
                    idx_n     = '0;
                    aborted_n = 1'b1;
                    state_n   = IDLE;
                end else if (accept) begin
                    word_n[{idx, 3'b000} +: 8] = in_data;
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) begin
                        // Present the completed word next cycle (WRITE).
                        addr_n  = ptr;
                        wdata_n = word_n;
                        wr_n    = 1'b1;
                        state_n = WRITE;
                    end
                end
            end
            WRITE: begin
                // The write on the bus this cycle always completes, even on abort.
                csum_n = checksum + mem_writedata;
                ptr_n  = (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
                rem_n  = rem - 1'b1;
                if (abort) begin
                    aborted_n = 1'b1;
                    state_n   = IDLE;
                end else if (rem == (ADDR_W + 1)'(1)) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = COLLECT;
                end
            end
            default: state_n = IDLE;
        endcase

        in_ready_n = (state_n == COLLECT);
        busy_n     = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            rem           <= '0;
            idx           <= '0;
            word          <= '0;
            in_ready      <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            mem_write     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            checksum      <= '0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            rem           <= rem_n;
            idx           <= idx_n;
            word          <= word_n;
            in_ready      <= in_ready_n;
            mem_address   <= addr_n;
            mem_writedata <= wdata_n;
            mem_write     <= wr_n;
            busy          <= busy_n;
            done          <= done_n;
            aborted       <= aborted_n;
            checksum      <= csum_n;
        end
    end

    assign mem_chipselect = mem_write;
    assign mem_byteenable = {4{mem_write}};
    assign cpu_reset_req  = busy;

endmodule

// File: tb/tb_niosfirmware_mem_loader.sv
// Self-checking bench for niosfirmware_mem_loader: table of complete loads
// plus hand-written sequences for zero count, abort, reset and spurious start.
module tb_niosfirmware_mem_loader;

    logic        clk = 1'b0;
    logic        reset, start, abort, in_valid;
    logic [10:0] base_addr;
    logic [11:0] word_count;
    logic [7:0]  in_data;
    logic        in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, aborted;
    logic [10:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata, checksum;

    niosfirmware_mem_loader dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .cpu_reset_req(cpu_reset_req),
        .busy(busy), .done(done), .aborted(aborted), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0]       base;
        logic [11:0]       cnt;
        int                nwords;
        logic [2:0][31:0]  w;
        logic [2:0][10:0]  a;
        logic [31:0]       csum;
    } vec_t;

    vec_t        vecs[4];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    logic [10:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          done_cnt, ab_cnt;
    logic [7:0]  bq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: log every write and check its strobes.
    always @(negedge clk) begin
        if (mem_write) begin
            chk("wr_strobes", {26'h0, mem_byteenable, mem_chipselect, in_ready},
                {26'h0, 4'hF, 1'b1, 1'b0});
            wa_q.push_back(mem_address);
            wd_q.push_back(mem_writedata);
            wc_q.push_back(cyc);
        end
        if (done)    done_cnt++;
        if (aborted) ab_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        done_cnt = 0; ab_cnt = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctrl"}, {22'h0, in_ready, mem_byteenable, mem_chipselect, mem_write,
                             cpu_reset_req, busy, done, aborted}, 32'h0);
        chk({tag, "_addr"},  32'(mem_address), 32'h0);
        chk({tag, "_wdata"}, mem_writedata, 32'h0);
        chk({tag, "_csum"},  checksum, 32'h0);
    endtask

    task automatic begin_load(input logic [10:0] b, input logic [11:0] c);
        @(negedge clk);
        start = 1'b1; base_addr = b; word_count = c;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", {29'h0, busy, in_ready, cpu_reset_req}, 32'h7);
    endtask

    // Drive bq[0..n-1] with in_valid held high; a byte advances only when
    // in_ready was high going into the edge. Optionally pulse a spurious start.
    task automatic feed(input int n, input bit spur);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 200) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = bq[k];
            if (spur) begin
                start      = (k == 5);
                base_addr  = 11'h555;
                word_count = 12'd1;
            end
            if (in_ready) k++;
            guard++;
        end
        if (k < n) chk("feed_timeout", 32'(k), 32'(n));
    endtask

    task automatic wait_end();
        int g = 0;
        while (!(done || aborted) && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("end_timeout", 32'(g), 32'd0);
    endtask

    task automatic run_vec(input int i, input bit spur);
        vec_t v;
        v = vecs[i];
        clear_logs();
        bq.delete();
        for (int wi = 0; wi < v.nwords; wi++)
            for (int bi = 0; bi < 4; bi++)
                bq.push_back(v.w[wi][8*bi +: 8]);
        begin_load(v.base, v.cnt);
        feed(bq.size(), spur);
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
        wait_end();
        chk($sformatf("v%0d_done", i), {30'h0, done, busy}, 32'h2);
        chk($sformatf("v%0d_csum", i), checksum, v.csum);
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
        chk($sformatf("v%0d_nwr", i), 32'(wa_q.size()), 32'(v.nwords));
        chk($sformatf("v%0d_ends", i), {done_cnt[15:0], ab_cnt[15:0]}, 32'h0001_0000);
        if (wa_q.size() == v.nwords) begin
            for (int wi = 0; wi < v.nwords; wi++) begin
                chk($sformatf("v%0d_addr%0d", i, wi), 32'(wa_q[wi]), 32'(v.a[wi]));
                chk($sformatf("v%0d_data%0d", i, wi), wd_q[wi], v.w[wi]);
            end
            if (v.nwords >= 2)
                chk($sformatf("v%0d_rate", i), 32'(wc_q[1] - wc_q[0]), 32'd5);
        end
    endtask

    initial begin
        vecs[0] = '{base: 11'h010, cnt: 12'd2, nwords: 2,
                    w: {32'h0, 32'h88776655, 32'h44332211},
                    a: {11'h0, 11'h011, 11'h010}, csum: 32'hCCAA8866};
        vecs[1] = '{base: 11'h7FF, cnt: 12'd2, nwords: 2,
                    w: {32'h0, 32'hFFFFFFFF, 32'h00000001},
                    a: {11'h0, 11'h000, 11'h7FF}, csum: 32'h00000000};
        vecs[2] = '{base: 11'h123, cnt: 12'd3, nwords: 3,
                    w: {32'hA0B0C0D0, 32'h10203040, 32'h01020304},
                    a: {11'h125, 11'h124, 11'h123}, csum: 32'hB1D2F414};
        vecs[3] = '{base: 11'h000, cnt: 12'd1, nwords: 1,
                    w: {32'h0, 32'h0, 32'hDEADBEEF},
                    a: {11'h0, 11'h0, 11'h000}, csum: 32'hDEADBEEF};

        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_data = 8'h0; base_addr = '0; word_count = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;

        // Table-driven loads; the first also carries a spurious start mid-load.
        for (int i = 0; i < 3; i++) run_vec(i, i == 0);

        // Zero-length load: done next cycle, checksum cleared, no write, never busy.
        clear_logs();
        @(negedge clk);
        start = 1'b1; base_addr = 11'h040; word_count = 12'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", {29'h0, done, busy, cpu_reset_req}, 32'h4);
        chk("zero_csum", checksum, 32'h0);
        @(negedge clk);
        chk("zero_after", {30'h0, done, busy}, 32'h0);
        repeat (3) @(negedge clk);
        chk("zero_nwr", 32'(wa_q.size()), 32'd0);

        // Abort after two bytes of word 3.
        clear_logs();
        bq.delete();
        for (int b = 1; b <= 10; b++) bq.push_back(8'(b));
        begin_load(11'h200, 12'd4);
        feed(10, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abc_pulse", {29'h0, aborted, done, busy}, 32'h4);
        @(negedge clk);
        chk("abc_after", 32'(aborted), 32'h0);
        chk("abc_nwr", 32'(wa_q.size()), 32'd2);
        chk("abc_ends", {done_cnt[15:0], ab_cnt[15:0]}, 32'h0000_0001);
        if (wa_q.size() == 2) begin
            chk("abc_w0", wd_q[0], 32'h04030201);
            chk("abc_w1", wd_q[1], 32'h08070605);
            chk("abc_a1", 32'(wa_q[1]), 32'h201);
        end

        // Abort during WRITE: that write still lands, aborted replaces done.
        clear_logs();
        bq.delete();
        for (int b = 0; b < 4; b++) bq.push_back(8'(8'hA0 + b));
        begin_load(11'h300, 12'd2);
        feed(4, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abw_pulse", {29'h0, aborted, done, busy}, 32'h4);
        @(negedge clk);
        chk("abw_nwr", 32'(wa_q.size()), 32'd1);
        chk("abw_ends", {done_cnt[15:0], ab_cnt[15:0]}, 32'h0000_0001);
        if (wa_q.size() == 1) begin
            chk("abw_addr", 32'(wa_q[0]), 32'h300);
            chk("abw_data", wd_q[0], 32'hA3A2A1A0);
        end

        // Reset mid-word, then a clean single-word load.
        clear_logs();
        bq.delete();
        for (int b = 0; b < 6; b++) bq.push_back(8'(8'h30 + b));
        begin_load(11'h050, 12'd2);
        feed(6, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        chk("midrst_nwr", 32'(wa_q.size()), 32'd1);
        reset = 1'b0;
        run_vec(3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
